ctrl_seq_microcode: RTL and testbench

//  Parametrised multi-cycle control unit. It is the successor to the single-cycle opcode->control-word ROM.
//  - Accepts a binary opcode over a valid/ready handshake.
//  - Dispatches the opcode to a micro-PC and emits one CTRL_W control word per cycle until the entry flagged 'last'.
//  - Dispatch and microcode tables are writable at run time. Sits between instruction fetch and the datapath.

---
 rtl/ctrl_seq_microcode_pkg.sv | 23 ++
 rtl/ctrl_seq_microcode_if.sv | 26 ++
 rtl/ctrl_seq_microcode_tables.sv | 78 +++++++
 rtl/ctrl_seq_microcode.sv | 127 ++++++++++++
 tb/tb_ctrl_seq_microcode.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_seq_microcode_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_seq_pkg
// Shared types and constants for the microcoded control sequencer.
//   state_t        : sequencer FSM states (IDLE, RUN)
//   UC_CTRL_LSB    : LSB of the ctrl field in a microcode word {last, ctrl}
//   DISP_UPC_LSB   : LSB of the start_upc field in a dispatch word {valid, start_upc}
//   NOP_CTRL_WORD  : all-zero control word, sliced to CTRL_W by users
// The flag bit of each word (last / valid) sits directly above its field,
// so its index is the field LSB plus the field width.
// ---------------------------------------------------------------------------
package ctrl_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int UC_CTRL_LSB  = 0;
    localparam int DISP_UPC_LSB = 0;

    localparam logic [63:0] NOP_CTRL_WORD = '0;

endpackage

// File: rtl/ctrl_seq_microcode_if.sv
// ---------------------------------------------------------------------------
// ctrl_seq_microcode_if
// Instruction handshake between fetch (master) and the sequencer (slave).
//   instr_valid : opcode offered by fetch
//   instr_ready : sequencer can accept (high only in IDLE)
//   opcode      : binary opcode, sampled on accept
// ---------------------------------------------------------------------------
interface ctrl_seq_microcode_if #(
    parameter int OPCODE_W = 6
);
    logic                instr_valid;
    logic                instr_ready;
    logic [OPCODE_W-1:0] opcode;

    modport master (
        output instr_valid,
        output opcode,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  opcode,
        output instr_ready
    );
endinterface

// File: rtl/ctrl_seq_microcode_tables.sv
// ---------------------------------------------------------------------------
// ctrl_seq_tables
// Dispatch table (opcode -> start micro-PC) and microcode store (upc ->
// {last, ctrl}). Both are plain register arrays, written on the rising edge
// and read asynchronously. Contents are not reset.
// Ports:
//   clk                                  : write clock
//   ucode_we/ucode_addr/ucode_wdata      : microcode write port ({last, ctrl})
//   disp_we/disp_addr/disp_wdata         : dispatch write port ({valid, start_upc})
//   upc -> uc_ctrl, uc_last              : microcode read port
//   opcode -> start_upc, entry_valid     : dispatch read port
// Build option CTRL_SEQ_ILLEGAL_TRAP_EN: when defined the dispatch valid bit
// is stored and returned on entry_valid; otherwise it is dropped and
// entry_valid is constant 1.
// ---------------------------------------------------------------------------
module ctrl_seq_tables
    import ctrl_seq_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CTRL_W   = 7,
    parameter int UPC_W    = 5
) (
    input  logic                clk,
    input  logic                ucode_we,
    input  logic [UPC_W-1:0]    ucode_addr,
    input  logic [CTRL_W:0]     ucode_wdata,
    input  logic                disp_we,
    input  logic [OPCODE_W-1:0] disp_addr,
    input  logic [UPC_W:0]      disp_wdata,
    input  logic [UPC_W-1:0]    upc,
    output logic [CTRL_W-1:0]   uc_ctrl,
    output logic                uc_last,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [UPC_W-1:0]    start_upc,
    output logic                entry_valid
);
    localparam int UC_LAST_BIT    = UC_CTRL_LSB + CTRL_W;
    localparam int DISP_VALID_BIT = DISP_UPC_LSB + UPC_W;

    logic [CTRL_W:0] ucode_mem [2**UPC_W];

    always_ff @(posedge clk) begin
        if (ucode_we) begin
            ucode_mem[ucode_addr] <= ucode_wdata;
        end
    end

    assign uc_ctrl = ucode_mem[upc][UC_LAST_BIT-1:UC_CTRL_LSB];
    assign uc_last = ucode_mem[upc][UC_LAST_BIT];

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    logic [UPC_W:0] disp_mem [2**OPCODE_W];

    always_ff @(posedge clk) begin
        if (disp_we) begin
            disp_mem[disp_addr] <= disp_wdata;
        end
    end

    assign start_upc   = disp_mem[opcode][DISP_VALID_BIT-1:DISP_UPC_LSB];
    assign entry_valid = disp_mem[opcode][DISP_VALID_BIT];
`else
    logic [UPC_W-1:0] disp_mem [2**OPCODE_W];
    logic             unused_valid;

    always_ff @(posedge clk) begin
        if (disp_we) begin
            disp_mem[disp_addr] <= disp_wdata[DISP_VALID_BIT-1:DISP_UPC_LSB];
        end
    end

    // Valid bit has no storage in this build; every entry dispatches.
    assign unused_valid = disp_wdata[DISP_VALID_BIT];
    assign start_upc    = disp_mem[opcode];
    assign entry_valid  = 1'b1;
`endif

endmodule

// File: rtl/ctrl_seq_microcode.sv
// ---------------------------------------------------------------------------
// ctrl_seq_microcode
// Multi-cycle microcoded control unit. An opcode accepted over the
// instruction handshake is dispatched to a start micro-PC; one control word
// per cycle is then driven to the datapath until the entry flagged 'last'.
// Ports:
//   clk, rst                 : clock (rising edge), async active-high reset
//   ibus (slave)             : instr_valid / instr_ready / opcode
//   stall                    : freeze micro-PC and hold ctrl_out
//   ctrl_out [CTRL_W]        : current control word (0 = NOP outside RUN)
//   busy                     : high while in RUN
//   done                     : high during the final micro-op cycle
//   illegal                  : 1-cycle pulse on an illegal opcode
//   ucode_we/addr/wdata      : microcode write port, {last, ctrl}
//   disp_we/addr/wdata       : dispatch write port, {valid, start_upc}
// Build option CTRL_SEQ_ILLEGAL_TRAP_EN: when defined, accepting an opcode
// whose dispatch entry is invalid pulses illegal and stays in IDLE; when
// undefined, illegal is tied to 0 and every opcode dispatches.
// ---------------------------------------------------------------------------
module ctrl_seq_microcode
    import ctrl_seq_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CTRL_W   = 7,
    parameter int UPC_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    ctrl_seq_microcode_if.slave ibus,
    input  logic                stall,
    output logic [CTRL_W-1:0]   ctrl_out,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    input  logic                ucode_we,
    input  logic [UPC_W-1:0]    ucode_addr,
    input  logic [CTRL_W:0]     ucode_wdata,
    input  logic                disp_we,
    input  logic [OPCODE_W-1:0] disp_addr,
    input  logic [UPC_W:0]      disp_wdata
);
    state_t             state;
    logic [UPC_W-1:0]   upc;
    logic               idle;
    logic               accept;
    logic               seq_end;
    logic [CTRL_W-1:0]  uc_ctrl;
    logic               uc_last;
    logic [UPC_W-1:0]   start_upc;
    logic               entry_valid;

    assign idle   = (state == IDLE);
    assign accept = ibus.instr_valid && idle;
    assign ibus.instr_ready = idle;

    // Table writes only take effect while idle. An accept in the same cycle
    // as a dispatch write reads the old entry, since the read is
    // combinational and the write lands on the edge.
    ctrl_seq_tables #(
        .OPCODE_W (OPCODE_W),
        .CTRL_W   (CTRL_W),
        .UPC_W    (UPC_W)
    ) u_tables (
        .clk         (clk),
        .ucode_we    (ucode_we && idle),
        .ucode_addr  (ucode_addr),
        .ucode_wdata (ucode_wdata),
        .disp_we     (disp_we && idle),
        .disp_addr   (disp_addr),
        .disp_wdata  (disp_wdata),
        .upc         (upc),
        .uc_ctrl     (uc_ctrl),
        .uc_last     (uc_last),
        .opcode      (ibus.opcode),
        .start_upc   (start_upc),
        .entry_valid (entry_valid)
    );

    // The top micro-PC entry always ends the sequence so upc never wraps.
    assign seq_end  = uc_last || (upc == {UPC_W{1'b1}});
    assign busy     = (state == RUN);
    assign ctrl_out = busy ? uc_ctrl : NOP_CTRL_WORD[CTRL_W-1:0];
    assign done     = busy && seq_end && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            upc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && entry_valid) begin
                        upc   <= start_upc;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (seq_end) begin
                            state <= IDLE;
                        end else begin
                            upc <= upc + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !entry_valid;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_seq_microcode.sv
// ---------------------------------------------------------------------------
// tb_ctrl_seq_microcode
// Directed testbench for ctrl_seq_microcode: reset/NOP, three-step opcode,
// stall behaviour, forced end at the top micro-PC, table write races,
// reset during RUN, and the illegal-opcode trap (build dependent).
// ---------------------------------------------------------------------------
module tb_ctrl_seq_microcode;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic [6:0] ctrl_out;
    logic       busy;
    logic       done;
    logic       illegal;
    logic       ucode_we;
    logic [4:0] ucode_addr;
    logic [7:0] ucode_wdata;
    logic       disp_we;
    logic [5:0] disp_addr;
    logic [5:0] disp_wdata;

    int tests = 0;
    int fails = 0;

    ctrl_seq_microcode_if #(.OPCODE_W(6)) ibus ();

    ctrl_seq_microcode #(
        .OPCODE_W (6),
        .CTRL_W   (7),
        .UPC_W    (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ibus        (ibus),
        .stall       (stall),
        .ctrl_out    (ctrl_out),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .ucode_we    (ucode_we),
        .ucode_addr  (ucode_addr),
        .ucode_wdata (ucode_wdata),
        .disp_we     (disp_we),
        .disp_addr   (disp_addr),
        .disp_wdata  (disp_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then leave 1 time unit so inputs change away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, then check the full output set.
    task automatic look(input string tag, input logic [6:0] c, input logic d,
                        input logic b, input logic r, input logic il);
        #1;
        chk({tag, ".ctrl"},    ctrl_out,         c);
        chk({tag, ".done"},    done,             d);
        chk({tag, ".busy"},    busy,             b);
        chk({tag, ".ready"},   ibus.instr_ready, r);
        chk({tag, ".illegal"}, illegal,          il);
    endtask

    task automatic uc_write(input logic [4:0] a, input logic [7:0] d);
        ucode_we    = 1'b1;
        ucode_addr  = a;
        ucode_wdata = d;
        tick();
        ucode_we    = 1'b0;
    endtask

    task automatic disp_write(input logic [5:0] a, input logic [5:0] d);
        disp_we    = 1'b1;
        disp_addr  = a;
        disp_wdata = d;
        tick();
        disp_we    = 1'b0;
    endtask

    initial begin
        rst              = 1'b0;
        stall            = 1'b0;
        ucode_we         = 1'b0;
        ucode_addr       = '0;
        ucode_wdata      = '0;
        disp_we          = 1'b0;
        disp_addr        = '0;
        disp_wdata       = '0;
        ibus.instr_valid = 1'b0;
        ibus.opcode      = '0;

        // 1: reset asserted between edges takes effect at once
        #2 rst = 1'b1;
        look("rst", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            look("nop", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // 2: three-step opcode
        disp_write(6'h04, {1'b1, 5'd2});
        uc_write(5'd2, {1'b0, 7'h1C});
        uc_write(5'd3, {1'b0, 7'h12});
        uc_write(5'd4, {1'b1, 7'h03});
        ibus.instr_valid = 1'b1;
        ibus.opcode      = 6'h04;
        look("t2.acc", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        ibus.instr_valid = 1'b0;
        look("t2.c1", 7'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        look("t2.c2", 7'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        look("t2.c3", 7'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        look("t2.end", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // 3: stall two cycles on the 12 entry, then one on the last entry
        ibus.instr_valid = 1'b1;
        ibus.opcode      = 6'h04;
        tick();
        ibus.instr_valid = 1'b0;
        look("t3.c1", 7'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        stall = 1'b1;
        look("t3.s1", 7'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        look("t3.s2", 7'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        stall = 1'b0;
        look("t3.s3", 7'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        stall = 1'b1;
        look("t3.lst", 7'h03, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        stall = 1'b0;
        look("t3.c3", 7'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        look("t3.end", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // 4: forced end at upc 31; instr_valid held so re-accept follows done by one cycle
        disp_write(6'h3C, {1'b1, 5'd31});
        uc_write(5'd31, {1'b0, 7'h7F});
        ibus.instr_valid = 1'b1;
        ibus.opcode      = 6'h3C;
        tick();
        look("t4.c1", 7'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        look("t4.idle", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        ibus.instr_valid = 1'b0;
        look("t4.re", 7'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        look("t4.end", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // 5: dispatch write racing an accept uses the old entry; ucode write in RUN ignored
        uc_write(5'd10, {1'b1, 7'h2A});
        ibus.instr_valid = 1'b1;
        ibus.opcode      = 6'h04;
        disp_we          = 1'b1;
        disp_addr        = 6'h04;
        disp_wdata       = {1'b1, 5'd10};
        tick();
        ibus.instr_valid = 1'b0;
        disp_we          = 1'b0;
        look("t5.old", 7'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        ucode_we    = 1'b1;
        ucode_addr  = 5'd3;
        ucode_wdata = {1'b1, 7'h55};
        tick();
        ucode_we = 1'b0;
        look("t5.keep", 7'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        look("t5.c3", 7'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        ibus.instr_valid = 1'b1;
        look("t5.idle", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        ibus.instr_valid = 1'b0;
        look("t5.new", 7'h2A, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // Reset in the middle of RUN aborts with no done
        disp_write(6'h04, {1'b1, 5'd2});
        ibus.instr_valid = 1'b1;
        tick();
        ibus.instr_valid = 1'b0;
        look("ab.c1", 7'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        look("ab.rst", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        look("ab.idle", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // 6: opcode with an invalid dispatch entry
        disp_write(6'h0F, {1'b0, 5'd0});
        uc_write(5'd0, {1'b1, 7'h41});
        ibus.instr_valid = 1'b1;
        ibus.opcode      = 6'h0F;
        tick();
        ibus.instr_valid = 1'b0;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
        look("t6.trap", 7'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        look("t6.after", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
`else
        look("t6.run", 7'h41, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        look("t6.after", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
